// File: rtl/conv3x3_window_feeder_pkg.sv
// Shared types and helpers for the 3x3 window feeder.
package conv3x3_pkg;

  localparam int KSIZE = 3;
  localparam int NTAPS = KSIZE * KSIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Tap number for window row r (0 = top/oldest) and column c (0 = left/oldest)
  function automatic int tap_idx(input int r, input int c);
    return KSIZE * r + c + 1;
  endfunction

endpackage

// File: rtl/conv3x3_window_feeder_if.sv
// Handshake/data bundle between the feeder and its pixel/weight sources and the conv engine.
// Optional macro WIN_COUNT_EN adds the 16-bit win_count signal.
interface conv3x3_window_feeder_if #(
  parameter int DW = 8
);
  import conv3x3_pkg::*;

  logic                  start;
  logic                  pix_valid;
  logic [DW-1:0]         pix_data;
  logic                  pix_ready;
  logic                  wgt_in_valid;
  logic [DW-1:0]         wgt_data;
  logic                  wgt_ready;
  logic                  weight_valid;
  logic [NTAPS*DW-1:0]   weight_vec;
  logic                  in_valid;
  logic [NTAPS*DW-1:0]   ifm_win;
  logic                  busy;
  logic                  frame_done;
`ifdef WIN_COUNT_EN
  logic [15:0]           win_count;

  modport master (
    output start, pix_valid, pix_data, wgt_in_valid, wgt_data,
    input  pix_ready, wgt_ready, weight_valid, weight_vec, in_valid, ifm_win,
           busy, frame_done, win_count
  );
  modport slave (
    input  start, pix_valid, pix_data, wgt_in_valid, wgt_data,
    output pix_ready, wgt_ready, weight_valid, weight_vec, in_valid, ifm_win,
           busy, frame_done, win_count
  );
`else
  modport master (
    output start, pix_valid, pix_data, wgt_in_valid, wgt_data,
    input  pix_ready, wgt_ready, weight_valid, weight_vec, in_valid, ifm_win,
           busy, frame_done
  );
  modport slave (
    input  start, pix_valid, pix_data, wgt_in_valid, wgt_data,
    output pix_ready, wgt_ready, weight_valid, weight_vec, in_valid, ifm_win,
           busy, frame_done
  );
`endif
endinterface

// File: rtl/conv3x3_window_feeder_line_buf.sv
// One image row of delay: o_data is the sample written DEPTH enabled cycles ago.
module conv3x3_line_buf #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  // Read-before-write at the pointer gives exactly DEPTH samples of delay
  assign o_data = r_mem[r_ptr];

  // Circular write with a shift enable; storage cleared on reset so no stale rows survive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (i_en) begin
      r_mem[r_ptr] <= i_data;
      r_ptr        <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
    end
  end
endmodule

// File: rtl/conv3x3_window_feeder.sv
// Front end for the 3x3 conv engine: serial weight load, raster pixel stream in,
// parallel 3x3 windows (valid convolution, stride 1) out.
// Optional macro WIN_COUNT_EN adds a per-frame window counter output.
//
// state  | meaning
// IDLE   | accepting weights; waits for start once 9 weights are loaded
// STREAM | accepting pixels, emitting windows
// DONE   | one cycle after the last pixel; frame_done pulse
module conv3x3_window_feeder
  import conv3x3_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input logic clk,
  input logic rst_n,
  conv3x3_window_feeder_if.slave bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [3:0]       WCNT_LAST = 4'(NTAPS - 1);

  state_e                  r_state;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic [3:0]              r_wcnt;
  logic                    r_weights_loaded;
  logic [(NTAPS-1)*DW-1:0] r_wgt_sr;
  logic                    r_pix_ready, r_wgt_ready, r_busy, r_frame_done;
  logic                    r_weight_valid, r_in_valid;
  logic [NTAPS*DW-1:0]     r_weight_vec, r_ifm_win;
  logic [DW-1:0]           r_win [KSIZE][KSIZE-1];

  logic                    w_pix_acc, w_wgt_acc, w_win_ok, w_frame_start;
  logic [NTAPS*DW-1:0]     w_wgt_shift, w_next_win;
  logic [DW-1:0]           w_lb1_q, w_lb2_q;
  logic [DW-1:0]           w_col [KSIZE];

  assign w_pix_acc     = bus.pix_valid & r_pix_ready;
  assign w_wgt_acc     = bus.wgt_in_valid & r_wgt_ready;
  assign w_win_ok      = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_frame_start = (r_state == IDLE) && bus.start && r_weights_loaded;
  // Newest weight enters at the top so tap 1 ends up in the low slice
  assign w_wgt_shift   = {bus.wgt_data, r_wgt_sr};

  conv3x3_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .i_en(w_pix_acc), .i_data(bus.pix_data), .o_data(w_lb1_q)
  );
  conv3x3_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .i_en(w_pix_acc), .i_data(w_lb1_q), .o_data(w_lb2_q)
  );

  // Incoming column: two rows up, one row up, current row
  assign w_col[0] = w_lb2_q;
  assign w_col[1] = w_lb1_q;
  assign w_col[2] = bus.pix_data;

  // Window as it will look once the incoming column is shifted in
  always_comb begin
    w_next_win = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        w_next_win[(tap_idx(r, c) - 1) * DW +: DW] = (c == KSIZE - 1) ? w_col[r] : r_win[r][c];
      end
    end
  end

  // Control FSM plus weight shift register, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_row            <= '0;
      r_col            <= '0;
      r_wcnt           <= '0;
      r_weights_loaded <= 1'b0;
      r_wgt_sr         <= '0;
      r_weight_vec     <= '0;
      r_weight_valid   <= 1'b0;
      r_pix_ready      <= 1'b0;
      r_wgt_ready      <= 1'b0;
      r_busy           <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_weight_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      if (w_wgt_acc) begin
        r_wgt_sr <= w_wgt_shift[NTAPS*DW-1:DW];
        if (r_wcnt == WCNT_LAST) begin
          r_wcnt           <= '0;
          r_weight_vec     <= w_wgt_shift;
          r_weight_valid   <= 1'b1;
          r_weights_loaded <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 4'd1;
        end
      end
      case (r_state)
        IDLE: begin
          r_wgt_ready <= 1'b1;
          if (w_frame_start) begin
            r_state     <= STREAM;
            r_row       <= '0;
            r_col       <= '0;
            r_busy      <= 1'b1;
            r_pix_ready <= 1'b1;
            r_wgt_ready <= 1'b0;
          end
        end
        STREAM: begin
          if (w_pix_acc) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              if (r_row == ROW_LAST) begin
                r_row        <= '0;
                r_state      <= DONE;
                r_busy       <= 1'b0;
                r_pix_ready  <= 1'b0;
                r_frame_done <= 1'b1;
              end else begin
                r_row <= r_row + ROW_W'(1);
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_wgt_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Column shift on every accepted pixel; publish the window only when fully inside the image
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE - 1; c++) r_win[r][c] <= '0;
      r_in_valid <= 1'b0;
      r_ifm_win  <= '0;
    end else begin
      r_in_valid <= w_pix_acc && w_win_ok;
      if (w_pix_acc) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 2; c++) r_win[r][c] <= r_win[r][c+1];
          r_win[r][KSIZE-2] <= w_col[r];
        end
        if (w_win_ok) r_ifm_win <= w_next_win;
      end
    end
  end

`ifdef WIN_COUNT_EN
  logic [15:0] r_win_count;

  // Windows emitted in the current frame; held after the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_win_count <= '0;
    else if (w_frame_start)        r_win_count <= '0;
    else if (w_pix_acc && w_win_ok) r_win_count <= r_win_count + 16'd1;
  end

  assign bus.win_count = r_win_count;
`endif

  assign bus.pix_ready    = r_pix_ready;
  assign bus.wgt_ready    = r_wgt_ready;
  assign bus.weight_valid = r_weight_valid;
  assign bus.weight_vec   = r_weight_vec;
  assign bus.in_valid     = r_in_valid;
  assign bus.ifm_win      = r_ifm_win;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_frame_done;
endmodule

// File: tb/tb_conv3x3_window_feeder.sv
// Bench for conv3x3_window_feeder: a 4x4 and an 8x8 instance share stimulus through a selector.
`timescale 1ns/1ps
module tb_conv3x3_window_feeder;
  import conv3x3_pkg::*;

  localparam int DW = 8;
  localparam int VW = NTAPS * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel, start, pix_valid, wgt_in_valid;
  logic [7:0] pix_data, wgt_data;

  conv3x3_window_feeder_if #(.DW(DW)) b4 ();
  conv3x3_window_feeder_if #(.DW(DW)) b8 ();

  assign b4.start        = start & ~sel;
  assign b8.start        = start & sel;
  assign b4.pix_valid    = pix_valid & ~sel;
  assign b8.pix_valid    = pix_valid & sel;
  assign b4.pix_data     = pix_data;
  assign b8.pix_data     = pix_data;
  assign b4.wgt_in_valid = wgt_in_valid;
  assign b8.wgt_in_valid = wgt_in_valid;
  assign b4.wgt_data     = wgt_data;
  assign b8.wgt_data     = wgt_data;

  wire          m_pix_ready    = sel ? b8.pix_ready    : b4.pix_ready;
  wire          m_wgt_ready    = sel ? b8.wgt_ready    : b4.wgt_ready;
  wire          m_weight_valid = sel ? b8.weight_valid : b4.weight_valid;
  wire [VW-1:0] m_weight_vec   = sel ? b8.weight_vec   : b4.weight_vec;
  wire          m_in_valid     = sel ? b8.in_valid     : b4.in_valid;
  wire [VW-1:0] m_ifm_win      = sel ? b8.ifm_win      : b4.ifm_win;
  wire          m_busy         = sel ? b8.busy         : b4.busy;
  wire          m_frame_done   = sel ? b8.frame_done   : b4.frame_done;
`ifdef WIN_COUNT_EN
  wire [15:0]   m_win_count    = sel ? b8.win_count    : b4.win_count;
`endif

  conv3x3_window_feeder #(.IMG_W(4), .IMG_H(4), .DW(DW)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  conv3x3_window_feeder #(.IMG_W(8), .IMG_H(8), .DW(DW)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] img [8][8];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [VW-1:0] pack9(input logic [7:0] v [NTAPS]);
    logic [VW-1:0] p;
    p = '0;
    for (int k = 1; k <= NTAPS; k++) p[k*DW-1 -: DW] = v[k-1];
    return p;
  endfunction

  task automatic load_weights(input logic [7:0] w [NTAPS]);
    for (int k = 0; k < NTAPS; k++) begin
      check("load_wgt_ready", m_wgt_ready, 1'b1);
      wgt_in_valid = 1'b1;
      wgt_data     = w[k];
      @(posedge clk); #1;
      check("load_weight_valid", m_weight_valid, k == NTAPS - 1);
    end
    wgt_in_valid = 1'b0;
    check("load_weight_vec", m_weight_vec, pack9(w));
    @(posedge clk); #1;
    check("load_weight_valid_drop", m_weight_valid, 1'b0);
  endtask

  // mode 0: continuous, 1: every other cycle, 2: random valid and random pixels
  task automatic run_frame(input int w, input int h, input int mode, input int abort_at,
                           input bit do_start, output logic [VW-1:0] first_win,
                           output logic [VW-1:0] last_win, output int nwin);
    int acc, cyc, r, c;
    bit drv_pv, seen_ready, exp_valid, exp_done, finished;
    logic [VW-1:0] exp_win, wv0;
    acc = 0; cyc = 0; nwin = 0; drv_pv = 0; seen_ready = 0; finished = 0;
    first_win = '0; last_win = '0;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++)
        img[i][j] = (mode == 2) ? 8'($urandom) : 8'(w * i + j);
    wv0 = m_weight_vec;
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("stream_entry_busy", m_busy, 1'b1);
    while (!finished && cyc < 2000) begin
      exp_valid = 0; exp_done = 0; exp_win = '0;
      if (drv_pv && seen_ready) begin
        r = acc / w;
        c = acc % w;
        if (r >= 2 && c >= 2) begin
          exp_valid = 1;
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              exp_win[(3*rr+cc+1)*DW-1 -: DW] = img[r-2+rr][c-2+cc];
        end
        exp_done = (acc == w * h - 1);
        acc++;
      end
      check("in_valid", m_in_valid, exp_valid);
      if (exp_valid) begin
        check("ifm_win", m_ifm_win, exp_win);
        if (nwin == 0) first_win = m_ifm_win;
        last_win = m_ifm_win;
        nwin++;
      end
      check("frame_done", m_frame_done, exp_done);
      check("busy", m_busy, !exp_done);
      check("wgt_ready_stream", m_wgt_ready, 1'b0);
      check("weight_valid_stream", m_weight_valid, 1'b0);
      if (exp_done || (abort_at >= 0 && acc == abort_at)) begin
        finished = 1;
      end else begin
        seen_ready = m_pix_ready;
        case (mode)
          0:       drv_pv = 1;
          1:       drv_pv = (cyc % 2 == 0);
          default: drv_pv = ($urandom_range(0, 3) != 0);
        endcase
        pix_valid    = drv_pv;
        pix_data     = img[acc / w][acc % w];
        wgt_in_valid = $urandom_range(0, 1) == 1;
        wgt_data     = 8'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    pix_valid = 1'b0;
    wgt_in_valid = 1'b0;
    if (!finished) check("frame_timeout", 1'b0, 1'b1);
    if (abort_at < 0) begin
      check("weight_vec_hold", m_weight_vec, wv0);
      @(posedge clk); #1;
      check("idle_in_valid", m_in_valid, 1'b0);
      check("idle_frame_done", m_frame_done, 1'b0);
      check("idle_busy", m_busy, 1'b0);
      check("idle_wgt_ready", m_wgt_ready, 1'b1);
      check("idle_ifm_hold", m_ifm_win, last_win);
      check("n_windows", nwin, (w - 2) * (h - 2));
`ifdef WIN_COUNT_EN
      check("win_count", m_win_count, nwin);
`endif
    end
  endtask

  typedef struct packed {
    logic       start;
    logic       wv;
    logic [7:0] wd;
    logic       e_busy;
    logic       e_pr;
    logic       e_wr;
    logic       e_wvld;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [VW-1:0] fw_exp, lw_exp, fwin, lwin;
    logic [7:0]    wl [NTAPS];
    logic [7:0]    fw [NTAPS];
    logic [7:0]    lw [NTAPS];
    int nwin;

    // start with no weights, load 1..9 (start on the 9th is ignored), then a real start
    tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < NTAPS; k++) wl[k] = 8'(k + 1);
    fw = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    lw = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    fw_exp = pack9(fw);
    lw_exp = pack9(lw);

    sel = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    wgt_in_valid = 1'b0; wgt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", m_busy, 1'b0);
    check("rst_pix_ready", m_pix_ready, 1'b0);
    check("rst_wgt_ready", m_wgt_ready, 1'b0);
    check("rst_in_valid", m_in_valid, 1'b0);
    check("rst_weight_vec", m_weight_vec, '0);
    check("rst_ifm_win", m_ifm_win, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      start        = tbl[i].start;
      wgt_in_valid = tbl[i].wv;
      wgt_data     = tbl[i].wd;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_busy", i), m_busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_pix_ready", i), m_pix_ready, tbl[i].e_pr);
      check($sformatf("tbl%0d_wgt_ready", i), m_wgt_ready, tbl[i].e_wr);
      check($sformatf("tbl%0d_weight_valid", i), m_weight_valid, tbl[i].e_wvld);
    end
    start = 1'b0;
    wgt_in_valid = 1'b0;
    check("weight_vec_1to9", m_weight_vec, pack9(wl));

    // 4x4 continuous (already in STREAM), then 4x4 alternating with weight noise
    run_frame(4, 4, 0, -1, 1'b0, fwin, lwin, nwin);
    check("c_first_win", fwin, fw_exp);
    check("c_last_win", lwin, lw_exp);
    run_frame(4, 4, 1, -1, 1'b1, fwin, lwin, nwin);
    check("a_first_win", fwin, fw_exp);
    check("a_last_win", lwin, lw_exp);

    // 8x8: reset after 20 pixels, confirm start is refused, reload, full random frame
    sel = 1'b1;
    @(posedge clk); #1;
    run_frame(8, 8, 2, 20, 1'b1, fwin, lwin, nwin);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", m_busy, 1'b0);
    check("mid_rst_pix_ready", m_pix_ready, 1'b0);
    check("mid_rst_in_valid", m_in_valid, 1'b0);
    check("mid_rst_weight_vec", m_weight_vec, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("nowgt_start_busy", m_busy, 1'b0);
    check("nowgt_start_pix_ready", m_pix_ready, 1'b0);
    for (int k = 0; k < NTAPS; k++) wl[k] = 8'($urandom);
    load_weights(wl);
    run_frame(8, 8, 2, -1, 1'b1, fwin, lwin, nwin);
    check("frame8_weight_vec", m_weight_vec, pack9(wl));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
